// File: rtl/set_assoc_cache_if.sv
// set_assoc_cache_if: request/response and line-memory bus of set_assoc_cache
// slave (cache side): takes is_input_valid/addr/mem_rw/din and mem_ready/mem_is_output_valid/mem_dout,
// drives is_ready/is_hit/is_output_valid/dout and mem_is_input_valid/mem_read/mem_write/mem_addr/mem_din.
// master (requester + memory side): the opposite directions.
interface set_assoc_cache_if #(
  parameter int LINE_SIZE  = 16,
  parameter int ADDR_WIDTH = 32
);
  localparam int OFF = $clog2(LINE_SIZE);
  logic                      is_input_valid, mem_rw, is_ready, is_output_valid, is_hit;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [31:0]               din, dout;
  logic                      mem_is_input_valid, mem_read, mem_write, mem_ready, mem_is_output_valid;
  logic [ADDR_WIDTH-OFF-1:0] mem_addr;
  logic [LINE_SIZE*8-1:0]    mem_din, mem_dout;
  modport slave (
    input  is_input_valid, addr, mem_rw, din, mem_ready, mem_is_output_valid, mem_dout,
    output is_ready, is_output_valid, dout, is_hit, mem_is_input_valid, mem_read, mem_write, mem_addr, mem_din
  );
  modport master (
    output is_input_valid, addr, mem_rw, din, mem_ready, mem_is_output_valid, mem_dout,
    input  is_ready, is_output_valid, dout, is_hit, mem_is_input_valid, mem_read, mem_write, mem_addr, mem_din
  );
endinterface

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative write-back/write-allocate data cache with true-LRU and hit/miss counters
// clk, reset (async active-low); bus: set_assoc_cache_if.slave (CPU request side + line-memory side);
// hit_count/miss_count: saturating statistics.
module set_assoc_cache #(
  parameter int LINE_SIZE  = 16,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  set_assoc_cache_if.slave bus,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);
  localparam int OFF = $clog2(LINE_SIZE);
  localparam int IDX = $clog2(NUM_SETS);
  localparam int TAG = ADDR_WIDTH - IDX - OFF;
  localparam int AGE = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
  localparam int LA  = ADDR_WIDTH - OFF;
  localparam logic [AGE-1:0] OLDEST = AGE'(NUM_WAYS - 1);
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOC_REQ, ALLOC_WAIT} state_t;
  state_t                 state_q, state_d;
  logic [NUM_WAYS-1:0]    valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]    dirty_q [NUM_SETS];
  logic [AGE-1:0]         age_q   [NUM_SETS][NUM_WAYS];
  logic [TAG-1:0]         tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_SIZE*8-1:0] line_q  [NUM_SETS][NUM_WAYS];
  logic [AGE-1:0]         vway_q, vway_d;
  logic [LA-1:0]          req_q;
  logic                   miss_pending_q;
  logic [31:0]            hit_count_q, miss_count_q;
  logic [TAG-1:0]         tag, ftag;
  logic [IDX-1:0]         idx, fidx, uidx;
  logic [OFF+2:0]         bofs;
  logic                   match, hit, miss, fill;
  logic [AGE-1:0]         hit_way, victim, uway, old_age;
  logic [AGE-1:0]         age_d [NUM_WAYS];

  assign tag  = bus.addr[ADDR_WIDTH-1 -: TAG];
  assign idx  = bus.addr[OFF +: IDX];
  assign bofs = {bus.addr[OFF-1:0] & ~OFF'(3), 3'b000};
  assign ftag = req_q[LA-1 -: TAG];
  assign fidx = req_q[IDX-1:0];
  assign hit  = bus.is_input_valid && state_q == IDLE && match;
  assign miss = bus.is_input_valid && state_q == IDLE && !match;
  assign fill = state_q == ALLOC_WAIT && bus.mem_is_output_valid;
  assign bus.is_ready        = state_q == IDLE;
  assign bus.is_hit          = hit;
  assign bus.is_output_valid = hit && !bus.mem_rw;
  assign bus.dout            = bus.is_output_valid ? line_q[idx][hit_way][bofs +: 32] : 32'd0;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Descending scans so the lowest-index way wins both the tag match and the victim choice.
  always_comb begin
    match   = 1'b0;
    hit_way = '0;
    victim  = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        match   = 1'b1;
        hit_way = AGE'(w);
      end
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (age_q[idx][w] == OLDEST) victim = AGE'(w);
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_q[idx][w]) victim = AGE'(w);
  end

  // An invalid way being filled counts as the oldest, so every valid way in the set ages by one.
  always_comb begin
    uidx    = fill ? fidx : idx;
    uway    = fill ? vway_q : hit_way;
    old_age = valid_q[uidx][uway] ? age_q[uidx][uway] : OLDEST;
    for (int w = 0; w < NUM_WAYS; w++)
      age_d[w] = AGE'(w) == uway ? '0 :
                 (valid_q[uidx][w] && age_q[uidx][w] < old_age) ? age_q[uidx][w] + 1'b1 : age_q[uidx][w];
  end

  always_comb begin
    state_d = state_q;
    vway_d  = vway_q;
    bus.mem_is_input_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_din   = '0;
    case (state_q)
      IDLE: if (miss) begin
        vway_d  = victim;
        state_d = valid_q[idx][victim] && dirty_q[idx][victim] ? WRITEBACK : ALLOC_REQ;
      end
      WRITEBACK: begin
        bus.mem_is_input_valid = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = {tag_q[fidx][vway_q], fidx};
        bus.mem_din   = line_q[fidx][vway_q];
        state_d = bus.mem_ready ? ALLOC_REQ : WRITEBACK;
      end
      ALLOC_REQ: begin
        bus.mem_is_input_valid = 1'b1;
        bus.mem_read = 1'b1;
        bus.mem_addr = req_q;
        state_d = bus.mem_ready ? ALLOC_WAIT : ALLOC_REQ;
      end
      default: state_d = bus.mem_is_output_valid ? IDLE : ALLOC_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      vway_q         <= '0;
      req_q          <= '0;
      miss_pending_q <= 1'b0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= '0;
      end
    end else begin
      state_q <= state_d;
      vway_q  <= vway_d;
      if (miss) begin
        req_q          <= bus.addr[ADDR_WIDTH-1:OFF];
        miss_pending_q <= 1'b1;
        miss_count_q   <= miss_count_q + {31'd0, ~&miss_count_q};
      end
      if (hit) begin
        miss_pending_q <= 1'b0;
        hit_count_q    <= hit_count_q + {31'd0, ~&hit_count_q & ~miss_pending_q};
        if (bus.mem_rw) dirty_q[idx][hit_way] <= 1'b1;
      end
      if (state_q == WRITEBACK && bus.mem_ready) dirty_q[fidx][vway_q] <= 1'b0;
      if (fill) begin
        valid_q[fidx][vway_q] <= 1'b1;
        dirty_q[fidx][vway_q] <= 1'b0;
      end
      if (hit || fill)
        for (int w = 0; w < NUM_WAYS; w++) age_q[uidx][w] <= age_d[w];
    end
  end

  // Tags and line data need no reset: they are only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (hit && bus.mem_rw) line_q[idx][hit_way][bofs +: 32] <= bus.din;
    if (fill) begin
      line_q[fidx][vway_q] <= bus.mem_dout;
      tag_q[fidx][vway_q]  <= ftag;
    end
  end
endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement. It sits between the pipeline's MEM stage and the block data memory. It generalises the direct-mapped cache in ways, sets and line size. Unlike a direct-mapped cache, it exports its memory-side port instead of instantiating memory, and it keeps hit/miss statistics.

## Interface
- LINE_SIZE, 16, bytes per line; power of two, at least 4
- NUM_SETS, 16, sets; power of two
- NUM_WAYS, 2, ways per set; power of two; 1 gives a direct-mapped cache
- ADDR_WIDTH, 32, byte-address width
- Derived widths:
  - OFF = CLOG2(LINE_SIZE)
  - IDX = CLOG2(NUM_SETS)
  - TAG = ADDR_WIDTH-IDX-OFF
  - AGE = max(1, CLOG2(NUM_WAYS))
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- is_input_valid  in  1  request present; requester holds addr/mem_rw/din stable until it sees is_hit=1
- addr  in  ADDR_WIDTH  byte address, word aligned
- mem_rw  in  1  0=read, 1=write
- din  in  32  write data
- is_ready  out  1  cache is in IDLE and can evaluate a request
- is_output_valid  out  1  dout valid (read hit)
- dout  out  32  read word
- is_hit  out  1  request hits this cycle
- mem_is_input_valid  out  1  memory request valid
- mem_read  out  1  line read request
- mem_write  out  1  line write request
- mem_addr  out  ADDR_WIDTH-OFF  line address
- mem_din  out  LINE_SIZE*8  write-back line
- mem_ready  in  1  memory accepts a request this cycle
- mem_is_output_valid  in  1  one-cycle pulse: read line on mem_dout
- mem_dout  in  LINE_SIZE*8  fill line
- hit_count  out  32  saturating count of requests that hit on first lookup
- miss_count  out  32  saturating count of misses

## Operation
- Address split: tag = addr[ADDR_WIDTH-1:IDX+OFF], index = addr[IDX+OFF-1:OFF], word = addr[OFF-1:2].
- Per-way state per set:
  - valid bit
  - dirty bit
  - tag
  - line
  - AGE-bit LRU age (0 = most recent)
- Lookup (combinational, IDLE only): is_hit=1 when is_input_valid and some valid way's tag matches. Multiple matches are illegal; the lowest way wins.
- Read hit: dout = selected word and is_output_valid=1 in the same cycle. Otherwise dout=0.
- Write hit: at the clock edge, write din into the word and set dirty.
- LRU update on every hit and fill:
  - accessed way age <= 0
  - every valid way in the set whose age < the old age increments
- Victim selection: the lowest-index invalid way; otherwise the way with age = NUM_WAYS-1.
- FSM states:
  - IDLE: on a miss, latch the victim way and request address, then go to WRITEBACK if the victim is valid and dirty, else to ALLOCATE.
  - WRITEBACK:
    - drive mem_is_input_valid=1, mem_write=1, mem_addr={victim tag, index}, mem_din=victim line
    - hold until mem_ready=1; at that edge clear the victim's dirty bit and go to ALLOCATE
  - ALLOCATE/REQ:
    - drive mem_is_input_valid=1, mem_read=1, mem_addr=request line address
    - hold until mem_ready=1, then go to ALLOCATE/WAIT
  - ALLOCATE/WAIT:
    - mem_* requests are 0
    - on mem_is_output_valid, write mem_dout into the victim, set valid=1, dirty=0, tag=request tag, update LRU, return to IDLE
  - The held request then re-looks up and hits.
- Statistics:
  - miss_count increments on each IDLE miss.
  - A miss_pending flag is set on a miss and cleared on the next hit.
  - hit_count increments only on hits with miss_pending=0, so a post-fill hit is not a second event.
  - Both counters saturate at 0xFFFF_FFFF.
- Outside the WRITEBACK and ALLOCATE/REQ states, mem_is_input_valid, mem_read, mem_write and mem_din are 0.

## Timing
- Reset (reset=0, asynchronous):
  - all valid, dirty and age bits = 0
  - FSM = IDLE
  - counters = 0
  - miss_pending = 0
  - is_ready=1; is_hit=0, is_output_valid=0, dout=0, all mem_* outputs=0
  - Reset mid-miss aborts the transaction; a later mem_is_output_valid is ignored in IDLE.
- Hit latency: 0 cycles; the result is valid in the cycle the request is presented.
- Clean miss, memory accepting immediately, fill L cycles after acceptance: the hit reappears L+2 cycles after the miss cycle.
- A dirty miss adds the write-back acceptance cycle(s).
- is_ready = (state==IDLE). It falls the cycle after a miss and rises the cycle after the fill.
- Line data never changes when is_input_valid=0. Address changes while is_input_valid=0 are ignored.

## Test plan
- Cold read of 0x100 -> miss_count=1, one mem read at line 0x10, then hit with dout=0x00000000 (memory init 0), hit_count=0.
- Write 0xDEADBEEF to 0x104, then read 0x104 -> both hit, dout=0xDEADBEEF, set 0 way 0 dirty.
- Then read 0x200 and 0x300 (all set 0) -> 0x200 fills way 1 with no write-back. 0x300 evicts LRU way 0: mem write at line 0x10 with 0xDEADBEEF in word 1, then a read at line 0x30.
- Re-read 0x104 after the step above -> miss, refilled from memory, dout=0xDEADBEEF; victim is the way holding 0x200.
- Hold mem_ready=0 for 5 cycles in WRITEBACK -> mem_is_input_valid and mem_din stay stable, is_ready=0 throughout.
- Assert reset low during ALLOCATE/WAIT, then deliver mem_is_output_valid -> no line becomes valid, read of 0x100 misses again, counters restart from 0.
